// File: rtl/video15k_pkg.sv
// Shared 15 kHz video definitions: default PAL raster timing, pattern encodings
// and 3:3:3 colour constants used by the sync generator and scandoubler benches.
`timescale 1ns/1ps
package video15k_pkg;

   // Default PAL-rate raster, in pixels (horizontal) and lines (vertical)
   localparam int H_ACTIVE = 320;
   localparam int H_FRONT  = 16;
   localparam int H_SYNC   = 32;
   localparam int H_BACK   = 80;
   localparam int V_ACTIVE = 256;
   localparam int V_FRONT  = 24;
   localparam int V_SYNC   = 4;
   localparam int V_BACK   = 28;

   // Counter width; covers H_TOTAL=448 and V_TOTAL=312
   localparam int CNT_W = 9;

   // pattern_sel encodings
   localparam logic [1:0] PAT_BARS  = 2'd0;
   localparam logic [1:0] PAT_GRID  = 2'd1;
   localparam logic [1:0] PAT_RAMP  = 2'd2;
   localparam logic [1:0] PAT_WHITE = 2'd3;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [2:0] b;
   } rgb_t;

   localparam rgb_t BLACK = '{r: 3'd0, g: 3'd0, b: 3'd0};
   localparam rgb_t WHITE = '{r: 3'd7, g: 3'd7, b: 3'd7};

   // Replicate one colour bit to a full-intensity 3-bit channel
   function automatic logic [2:0] rep3(input logic bit_i);
      return {3{bit_i}};
   endfunction

endpackage

// File: rtl/video_sync_gen15k_tpg_pattern.sv
// Test-pattern source: tracks the current bar (H_ACTIVE/8 pixels wide) with a
// small counter kept in lock-step with hcnt, then decodes the selected pattern.
// Output is raw colour; blanking outside the active area is applied by the top.
`timescale 1ns/1ps
module tpg_pattern
   import video15k_pkg::*;
#(
   parameter int H_ACTIVE_P = H_ACTIVE,
   parameter int H_TOTAL_P  = H_ACTIVE + H_FRONT + H_SYNC + H_BACK,
   parameter int V_ACTIVE_P = V_ACTIVE
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [CNT_W-1:0] hcnt,
   input  logic [CNT_W-1:0] vcnt,
   input  logic [1:0]       sel,
   output rgb_t             rgb
);

   localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL_P - 1);
   localparam logic [CNT_W-1:0] SUB_LAST   = CNT_W'(H_ACTIVE_P / 8 - 1);
   localparam logic [CNT_W-1:0] H_ACT_LAST = CNT_W'(H_ACTIVE_P - 1);
   localparam logic [CNT_W-1:0] V_ACT_LAST = CNT_W'(V_ACTIVE_P - 1);

   logic [2:0]       bar_q, bar_d;
   logic [CNT_W-1:0] sub_q, sub_d;
   logic [2:0]       idx;

   // Bar/sub-pixel counters: both describe the pixel hcnt currently points at
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bar_q <= '0;
         sub_q <= '0;
      end else begin
         bar_q <= bar_d;
         sub_q <= sub_d;
      end
   end

   // Restart with the line, step the bar at each boundary (wraps harmlessly in blanking)
   always_comb begin
      bar_d = bar_q;
      sub_d = sub_q + 1'b1;
      if (hcnt == H_LAST) begin
         bar_d = '0;
         sub_d = '0;
      end else if (sub_q == SUB_LAST) begin
         sub_d = '0;
         bar_d = bar_q + 1'b1;
      end
   end

   // Pattern decode; bar colour index runs white (7) down to black (0)
   always_comb begin
      idx = ~bar_q;
      rgb = BLACK;
      case (sel)
         PAT_BARS:  rgb = '{r: rep3(idx[1]), g: rep3(idx[2]), b: rep3(idx[0])};
         PAT_GRID:  begin
            if (hcnt[3:0] == 4'd0 || vcnt[3:0] == 4'd0 ||
                hcnt == H_ACT_LAST || vcnt == V_ACT_LAST)
               rgb = WHITE;
         end
         PAT_RAMP:  rgb = '{r: bar_q, g: bar_q, b: bar_q};
         default:   rgb = WHITE;
      endcase
   end

endmodule

// File: rtl/video_sync_gen15k.sv
// 15 kHz raster generator: h/v counters, region decode, sync and composite sync,
// frame-boundary pattern latch and a single output register stage so colour,
// syncs and active all leave on the same clkvideo edge.
`timescale 1ns/1ps
module video_sync_gen15k
   import video15k_pkg::*;
#(
   parameter int H_ACTIVE_P = H_ACTIVE,
   parameter int H_FRONT_P  = H_FRONT,
   parameter int H_SYNC_P   = H_SYNC,
   parameter int H_BACK_P   = H_BACK,
   parameter int V_ACTIVE_P = V_ACTIVE,
   parameter int V_FRONT_P  = V_FRONT,
   parameter int V_SYNC_P   = V_SYNC,
   parameter int V_BACK_P   = V_BACK
) (
   input  logic       clkvideo,
   input  logic       rst_n,
   input  logic [1:0] pattern_sel,
   output logic [2:0] r,
   output logic [2:0] g,
   output logic [2:0] b,
   output logic       hsync_n,
   output logic       vsync_n,
   output logic       csync_n,
   output logic       active,
   output logic       frame_start
);

   localparam int H_TOTAL = H_ACTIVE_P + H_FRONT_P + H_SYNC_P + H_BACK_P;
   localparam int V_TOTAL = V_ACTIVE_P + V_FRONT_P + V_SYNC_P + V_BACK_P;

   localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE_P);
   localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE_P);
   localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE_P + H_FRONT_P);
   localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE_P + H_FRONT_P + H_SYNC_P);
   localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE_P + V_FRONT_P);
   localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE_P + V_FRONT_P + V_SYNC_P);

   logic [CNT_W-1:0] hcnt_q, hcnt_d;
   logic [CNT_W-1:0] vcnt_q, vcnt_d;
   logic [1:0]       pat_q, pat_d, pat_cur;
   logic             frame_top;
   logic             act_c, hs_c, vs_c;
   rgb_t             pix;

   rgb_t             rgb_q, rgb_d;
   logic             hsync_n_q, hsync_n_d;
   logic             vsync_n_q, vsync_n_d;
   logic             csync_n_q, csync_n_d;
   logic             active_q, active_d;
   logic             frame_start_q, frame_start_d;

   tpg_pattern #(
      .H_ACTIVE_P (H_ACTIVE_P),
      .H_TOTAL_P  (H_TOTAL),
      .V_ACTIVE_P (V_ACTIVE_P)
   ) u_tpg (
      .clk   (clkvideo),
      .rst_n (rst_n),
      .hcnt  (hcnt_q),
      .vcnt  (vcnt_q),
      .sel   (pat_cur),
      .rgb   (pix)
   );

   // Raster counters: hcnt wraps each line, vcnt advances on hcnt wrap
   always_comb begin
      hcnt_d = hcnt_q + 1'b1;
      vcnt_d = vcnt_q;
      if (hcnt_q == H_LAST) begin
         hcnt_d = '0;
         vcnt_d = (vcnt_q == V_LAST) ? '0 : vcnt_q + 1'b1;
      end
   end

   // Pattern latch: the first pixel of a frame already uses the freshly sampled select
   always_comb begin
      frame_top = (hcnt_q == '0) && (vcnt_q == '0);
      pat_cur   = frame_top ? pattern_sel : pat_q;
      pat_d     = pat_cur;
   end

   // Region decode and next output values (one register stage keeps everything aligned)
   always_comb begin
      act_c         = (hcnt_q < H_ACT) && (vcnt_q < V_ACT);
      hs_c          = (hcnt_q >= HS_START) && (hcnt_q < HS_END);
      vs_c          = (vcnt_q >= VS_START) && (vcnt_q < VS_END);
      rgb_d         = act_c ? pix : BLACK;
      hsync_n_d     = ~hs_c;
      vsync_n_d     = ~vs_c;
      // During vsync lines the hsync slot is inverted (serration)
      csync_n_d     = ~(vs_c ^ hs_c);
      active_d      = act_c;
      frame_start_d = frame_top;
   end

   // All state and output registers; reset forces idle sync levels and blank video
   always_ff @(posedge clkvideo or negedge rst_n) begin
      if (!rst_n) begin
         hcnt_q        <= '0;
         vcnt_q        <= '0;
         pat_q         <= PAT_BARS;
         rgb_q         <= BLACK;
         hsync_n_q     <= 1'b1;
         vsync_n_q     <= 1'b1;
         csync_n_q     <= 1'b1;
         active_q      <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcnt_q        <= hcnt_d;
         vcnt_q        <= vcnt_d;
         pat_q         <= pat_d;
         rgb_q         <= rgb_d;
         hsync_n_q     <= hsync_n_d;
         vsync_n_q     <= vsync_n_d;
         csync_n_q     <= csync_n_d;
         active_q      <= active_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign r           = rgb_q.r;
   assign g           = rgb_q.g;
   assign b           = rgb_q.b;
   assign hsync_n     = hsync_n_q;
   assign vsync_n     = vsync_n_q;
   assign csync_n     = csync_n_q;
   assign active      = active_q;
   assign frame_start = frame_start_q;

endmodule
